// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// instruction classes, opcode/funct values and datapath mux select codes.
package cu_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_F_WAIT, S_IR_LOAD, S_DECODE,
    S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB,
    S_MEM_ADDR, S_LW_RD, S_LW_WAIT, S_LW_MDR, S_LW_WB, S_SW_WR,
    S_BRANCH, S_JUMP, S_RTE, S_MULT_START, S_MULT_WAIT,
    S_EXC_EPC, S_EXC_RD, S_EXC_WAIT, S_EXC_JMP
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_MULT, C_RTE, C_ADDI,
    C_LW, C_SW, C_BEQ, C_BNE, C_J, C_INVALID
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_RTE  = 6'h13;

  localparam logic [3:0] ALU_PASS_A = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;

  localparam logic [1:0] PC_SRC_ALUOUT = 2'd0;
  localparam logic [1:0] PC_SRC_ALUREG = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_EPC    = 2'd3;

  localparam logic [1:0] MEM_SRC_PC     = 2'd0;
  localparam logic [1:0] MEM_SRC_ALUREG = 2'd1;
  localparam logic [1:0] MEM_SRC_DIVM   = 2'd2;
  localparam logic [1:0] MEM_SRC_VECTOR = 2'd3;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_A   = 2'd1;
  localparam logic [1:0] SRCA_MEM = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] WRB_RT = 2'd0;
  localparam logic [1:0] WRB_RD = 2'd1;

  localparam logic [1:0] EXC_INVALID  = 2'd0;
  localparam logic [1:0] EXC_OVERFLOW = 2'd1;
  localparam logic [1:0] EXC_DIVZERO  = 2'd2;

  function automatic logic [3:0] alu_op_for(input instr_class_t c);
    case (c)
      C_SUB:   return ALU_SUB;
      C_AND:   return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction classifier: maps IR opcode/funct onto an
// instruction class and flags anything outside the supported subset.
module cu_decode
  import cu_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic         invalid
);

  always_comb begin
    instr_class = C_INVALID;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  instr_class = C_ADD;
          FN_SUB:  instr_class = C_SUB;
          FN_AND:  instr_class = C_AND;
          FN_MULT: instr_class = C_MULT;
          FN_RTE:  instr_class = C_RTE;
          default: instr_class = C_INVALID;
        endcase
      end
      OP_ADDI: instr_class = C_ADDI;
      OP_LW:   instr_class = C_LW;
      OP_SW:   instr_class = C_SW;
      OP_BEQ:  instr_class = C_BEQ;
      OP_BNE:  instr_class = C_BNE;
      OP_J:    instr_class = C_J;
      default: instr_class = C_INVALID;
    endcase
    invalid = (instr_class == C_INVALID);
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath: sequences fetch,
// decode, execute, memory, writeback, the mult handshake and exceptions.
module control_unit
  import cu_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  input  logic       OVERFLOW,
  input  logic       mult_end,
  output logic       PC_w,
  output logic       EPC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       RB_w,
  output logic       A_w,
  output logic       B_w,
  output logic       ALUOut_w,
  output logic       MEM_DATA_REG_w,
  output logic       HI_w,
  output logic       LO_w,
  output logic       mult_control,
  output logic [1:0] Mux_PC,
  output logic [1:0] Mux_MEM,
  output logic [1:0] Mux_EXC,
  output logic [1:0] Mux_ALUSrcA,
  output logic [1:0] Mux_ALUSrcB,
  output logic [1:0] Mux_W_RB,
  output logic [3:0] ALUOp,
  output logic [1:0] LS_control,
  output logic [1:0] SS_control
);

  localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
  localparam logic [7:0] WAIT_LOAD = 8'(HAS_WAIT ? MEM_WAIT - 1 : 0);

  state_t       state;
  logic [7:0]   wait_cnt;
  logic [1:0]   exc_code;
  instr_class_t instr_class;
  logic         invalid;
  logic         arith_ovf;

  cu_decode u_decode (
    .opcode      (OPCODE),
    .funct       (FUNCT),
    .instr_class (instr_class),
    .invalid     (invalid)
  );

  // Only add/sub/addi trap on overflow; and never does.
  assign arith_ovf = OVERFLOW && (instr_class != C_AND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      exc_code <= '0;
    end else begin
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          wait_cnt <= WAIT_LOAD;
          state    <= HAS_WAIT ? S_F_WAIT : S_IR_LOAD;
        end
        S_F_WAIT:
          if (wait_cnt == 8'd0) state <= S_IR_LOAD;
          else                  wait_cnt <= wait_cnt - 8'd1;
        S_IR_LOAD: state <= S_DECODE;
        S_DECODE: begin
          if (invalid) begin
            state    <= S_EXC_EPC;
            exc_code <= EXC_INVALID;
          end else begin
            case (instr_class)
              C_ADD, C_SUB, C_AND: state <= S_R_EXEC;
              C_MULT:              state <= S_MULT_START;
              C_RTE:               state <= S_RTE;
              C_ADDI:              state <= S_ADDI_EXEC;
              C_LW, C_SW:          state <= S_MEM_ADDR;
              C_BEQ, C_BNE:        state <= S_BRANCH;
              default:             state <= S_JUMP;
            endcase
          end
        end
        S_R_EXEC, S_ADDI_EXEC: begin
          if (arith_ovf) begin
            state    <= S_EXC_EPC;
            exc_code <= EXC_OVERFLOW;
          end else begin
            state <= (state == S_R_EXEC) ? S_R_WB : S_ADDI_WB;
          end
        end
        S_MEM_ADDR: state <= (instr_class == C_LW) ? S_LW_RD : S_SW_WR;
        S_LW_RD: begin
          wait_cnt <= WAIT_LOAD;
          state    <= HAS_WAIT ? S_LW_WAIT : S_LW_MDR;
        end
        S_LW_WAIT:
          if (wait_cnt == 8'd0) state <= S_LW_MDR;
          else                  wait_cnt <= wait_cnt - 8'd1;
        S_LW_MDR:     state <= S_LW_WB;
        S_MULT_START: state <= S_MULT_WAIT;
        S_MULT_WAIT:  if (mult_end) state <= S_FETCH;
        S_EXC_EPC:    state <= S_EXC_RD;
        S_EXC_RD: begin
          wait_cnt <= WAIT_LOAD;
          state    <= HAS_WAIT ? S_EXC_WAIT : S_EXC_JMP;
        end
        S_EXC_WAIT:
          if (wait_cnt == 8'd0) state <= S_EXC_JMP;
          else                  wait_cnt <= wait_cnt - 8'd1;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PC_w = 1'b0; EPC_w = 1'b0; MEM_w = 1'b0; IR_w = 1'b0; RB_w = 1'b0;
    A_w = 1'b0; B_w = 1'b0; ALUOut_w = 1'b0; MEM_DATA_REG_w = 1'b0;
    HI_w = 1'b0; LO_w = 1'b0; mult_control = 1'b0;
    Mux_PC = '0; Mux_MEM = '0; Mux_EXC = '0; Mux_ALUSrcA = '0;
    Mux_ALUSrcB = '0; Mux_W_RB = '0; ALUOp = '0;
    LS_control = 2'b00; SS_control = 2'b00;
    case (state)
      S_FETCH, S_F_WAIT: Mux_MEM = MEM_SRC_PC;
      S_IR_LOAD: begin
        IR_w = 1'b1; Mux_ALUSrcA = SRCA_PC; Mux_ALUSrcB = SRCB_FOUR;
        ALUOp = ALU_ADD; PC_w = 1'b1; Mux_PC = PC_SRC_ALUOUT;
      end
      // Branch target is precomputed here while A/B are captured.
      S_DECODE: begin
        A_w = 1'b1; B_w = 1'b1; Mux_ALUSrcA = SRCA_PC;
        Mux_ALUSrcB = SRCB_IMM_SH2; ALUOp = ALU_ADD; ALUOut_w = 1'b1;
      end
      S_R_EXEC: begin
        Mux_ALUSrcA = SRCA_A; Mux_ALUSrcB = SRCB_B;
        ALUOp = alu_op_for(instr_class); ALUOut_w = 1'b1;
      end
      S_R_WB: begin RB_w = 1'b1; Mux_W_RB = WRB_RD; end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        Mux_ALUSrcA = SRCA_A; Mux_ALUSrcB = SRCB_IMM;
        ALUOp = ALU_ADD; ALUOut_w = 1'b1;
      end
      S_ADDI_WB, S_LW_WB: begin RB_w = 1'b1; Mux_W_RB = WRB_RT; end
      S_LW_RD, S_LW_WAIT: Mux_MEM = MEM_SRC_ALUREG;
      S_LW_MDR: begin Mux_MEM = MEM_SRC_ALUREG; MEM_DATA_REG_w = 1'b1; end
      S_SW_WR:  begin Mux_MEM = MEM_SRC_ALUREG; MEM_w = 1'b1; end
      S_BRANCH: begin
        Mux_ALUSrcA = SRCA_A; Mux_ALUSrcB = SRCB_B; ALUOp = ALU_SUB;
        PC_w = (instr_class == C_BEQ) ? ZERO : ~ZERO;
        Mux_PC = PC_SRC_ALUREG;
      end
      S_JUMP:       begin PC_w = 1'b1; Mux_PC = PC_SRC_JUMP; end
      S_RTE:        begin PC_w = 1'b1; Mux_PC = PC_SRC_EPC; end
      S_MULT_START: mult_control = 1'b1;
      S_MULT_WAIT:  begin HI_w = mult_end; LO_w = mult_end; end
      // PC already points past the faulting word; step back by 4.
      S_EXC_EPC: begin
        Mux_ALUSrcA = SRCA_PC; Mux_ALUSrcB = SRCB_FOUR;
        ALUOp = ALU_SUB; ALUOut_w = 1'b1;
      end
      S_EXC_RD: begin EPC_w = 1'b1; Mux_MEM = MEM_SRC_VECTOR; Mux_EXC = exc_code; end
      S_EXC_WAIT: begin Mux_MEM = MEM_SRC_VECTOR; Mux_EXC = exc_code; end
      S_EXC_JMP: begin
        Mux_ALUSrcA = SRCA_MEM; ALUOp = ALU_PASS_A;
        PC_w = 1'b1; Mux_PC = PC_SRC_ALUOUT;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: a per-instruction schedule model built
// from the instruction set rules predicts every output on every cycle.
module tb_control_unit;

  localparam int MEM_WAIT = 1;

  typedef struct packed {
    logic pc_w, epc_w, mem_w, ir_w, rb_w, a_w, b_w, aluout_w, mdr_w, hi_w, lo_w, mult_control;
    logic [1:0] mux_pc, mux_mem, mux_exc, src_a, src_b, w_rb;
    logic [3:0] alu_op;
    logic [1:0] ls, ss;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] OPCODE, FUNCT;
  logic ZERO, OVERFLOW, mult_end;
  logic PC_w, EPC_w, MEM_w, IR_w, RB_w, A_w, B_w, ALUOut_w, MEM_DATA_REG_w, HI_w, LO_w;
  logic mult_control;
  logic [1:0] Mux_PC, Mux_MEM, Mux_EXC, Mux_ALUSrcA, Mux_ALUSrcB, Mux_W_RB;
  logic [3:0] ALUOp;
  logic [1:0] LS_control, SS_control;

  int n_checks = 0;
  int n_fail   = 0;
  ctl_t obs;
  ctl_t w;

  always #5 clk = ~clk;

  control_unit #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .ZERO(ZERO), .OVERFLOW(OVERFLOW), .mult_end(mult_end),
    .PC_w(PC_w), .EPC_w(EPC_w), .MEM_w(MEM_w), .IR_w(IR_w), .RB_w(RB_w),
    .A_w(A_w), .B_w(B_w), .ALUOut_w(ALUOut_w), .MEM_DATA_REG_w(MEM_DATA_REG_w),
    .HI_w(HI_w), .LO_w(LO_w), .mult_control(mult_control),
    .Mux_PC(Mux_PC), .Mux_MEM(Mux_MEM), .Mux_EXC(Mux_EXC),
    .Mux_ALUSrcA(Mux_ALUSrcA), .Mux_ALUSrcB(Mux_ALUSrcB), .Mux_W_RB(Mux_W_RB),
    .ALUOp(ALUOp), .LS_control(LS_control), .SS_control(SS_control)
  );

  assign obs = {PC_w, EPC_w, MEM_w, IR_w, RB_w, A_w, B_w, ALUOut_w, MEM_DATA_REG_w,
                HI_w, LO_w, mult_control, Mux_PC, Mux_MEM, Mux_EXC, Mux_ALUSrcA,
                Mux_ALUSrcB, Mux_W_RB, ALUOp, LS_control, SS_control};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Flags that should not matter in the current cycle get random values.
  task automatic rnd_flags();
    ZERO     = 1'($urandom_range(0, 1));
    OVERFLOW = 1'($urandom_range(0, 1));
    mult_end = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with inputs set; checks, then advances one cycle.
  task automatic cyc(input string tag, input ctl_t want);
    #1;
    check(tag, obs, want);
    @(negedge clk);
  endtask

  function automatic string kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h20: return "add";
          6'h22: return "sub";
          6'h24: return "and";
          6'h18: return "mult";
          6'h13: return "rte";
          default: return "inv";
        endcase
      end
      6'h08: return "addi";
      6'h23: return "lw";
      6'h2B: return "sw";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h02: return "j";
      default: return "inv";
    endcase
  endfunction

  task automatic fetch_decode();
    ctl_t e;
    rnd_flags(); cyc("fetch", '0);
    repeat (MEM_WAIT) begin rnd_flags(); cyc("fetch_wait", '0); end
    e = '0; e.ir_w = 1; e.src_b = 2'd1; e.alu_op = 4'd1; e.pc_w = 1; e.mux_pc = 2'd0;
    rnd_flags(); cyc("ir_load", e);
    e = '0; e.a_w = 1; e.b_w = 1; e.src_b = 2'd3; e.alu_op = 4'd1; e.aluout_w = 1;
    rnd_flags(); cyc("decode", e);
  endtask

  task automatic exc_seq(input logic [1:0] code);
    ctl_t e;
    e = '0; e.src_a = 2'd0; e.src_b = 2'd1; e.alu_op = 4'd2; e.aluout_w = 1;
    rnd_flags(); cyc("exc_epc", e);
    e = '0; e.epc_w = 1; e.mux_mem = 2'd3; e.mux_exc = code;
    rnd_flags(); cyc("exc_rd", e);
    repeat (MEM_WAIT) begin
      e = '0; e.mux_mem = 2'd3; e.mux_exc = code;
      rnd_flags(); cyc("exc_wait", e);
    end
    e = '0; e.src_a = 2'd2; e.alu_op = 4'd0; e.pc_w = 1; e.mux_pc = 2'd0;
    rnd_flags(); cyc("exc_jmp", e);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit ovf, input bit zero, input int mwait);
    string k;
    ctl_t e;
    k = kind_of(op, fn);
    OPCODE = op;
    FUNCT  = fn;
    fetch_decode();
    if (k == "add" || k == "sub" || k == "and") begin
      e = '0; e.src_a = 2'd1; e.src_b = 2'd0; e.aluout_w = 1;
      e.alu_op = (k == "add") ? 4'd1 : (k == "sub") ? 4'd2 : 4'd3;
      rnd_flags(); OVERFLOW = ovf; cyc("r_exec", e);
      if (ovf && k != "and") exc_seq(2'd1);
      else begin
        e = '0; e.rb_w = 1; e.w_rb = 2'd1;
        rnd_flags(); cyc("r_wb", e);
      end
    end else if (k == "addi") begin
      e = '0; e.src_a = 2'd1; e.src_b = 2'd2; e.alu_op = 4'd1; e.aluout_w = 1;
      rnd_flags(); OVERFLOW = ovf; cyc("addi_exec", e);
      if (ovf) exc_seq(2'd1);
      else begin
        e = '0; e.rb_w = 1; e.w_rb = 2'd0;
        rnd_flags(); cyc("addi_wb", e);
      end
    end else if (k == "lw" || k == "sw") begin
      e = '0; e.src_a = 2'd1; e.src_b = 2'd2; e.alu_op = 4'd1; e.aluout_w = 1;
      rnd_flags(); cyc("mem_addr", e);
      if (k == "lw") begin
        e = '0; e.mux_mem = 2'd1;
        rnd_flags(); cyc("lw_rd", e);
        repeat (MEM_WAIT) begin rnd_flags(); cyc("lw_wait", e); end
        e = '0; e.mux_mem = 2'd1; e.mdr_w = 1;
        rnd_flags(); cyc("lw_mdr", e);
        e = '0; e.rb_w = 1; e.w_rb = 2'd0;
        rnd_flags(); cyc("lw_wb", e);
      end else begin
        e = '0; e.mux_mem = 2'd1; e.mem_w = 1;
        rnd_flags(); cyc("sw_wr", e);
      end
    end else if (k == "beq" || k == "bne") begin
      e = '0; e.src_a = 2'd1; e.src_b = 2'd0; e.alu_op = 4'd2; e.mux_pc = 2'd1;
      e.pc_w = (k == "beq") ? zero : !zero;
      rnd_flags(); ZERO = zero; cyc("branch", e);
    end else if (k == "j") begin
      e = '0; e.pc_w = 1; e.mux_pc = 2'd2;
      rnd_flags(); cyc("jump", e);
    end else if (k == "rte") begin
      e = '0; e.pc_w = 1; e.mux_pc = 2'd3;
      rnd_flags(); cyc("rte", e);
    end else if (k == "mult") begin
      e = '0; e.mult_control = 1;
      rnd_flags(); cyc("mult_start", e);
      for (int i = 1; i < mwait; i++) begin
        rnd_flags(); mult_end = 1'b0; cyc("mult_wait", '0);
      end
      e = '0; e.hi_w = 1; e.lo_w = 1;
      rnd_flags(); mult_end = 1'b1; cyc("mult_done", e);
    end else begin
      exc_seq(2'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [5:0] op, fn;
    logic [5:0] ops [12];
    logic [5:0] fns [6];
    ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h18, 6'h13, 6'h00};

    reset = 1'b0; OPCODE = '0; FUNCT = '0; ZERO = 0; OVERFLOW = 0; mult_end = 0;
    #1 check("reset_async", obs, '0);
    repeat (3) begin @(negedge clk); rnd_flags(); #1 check("reset_hold", obs, '0); end
    @(negedge clk); reset = 1'b1;
    rnd_flags(); cyc("reset_release", '0);

    run_instr(6'h00, 6'h20, 0, 0, 1);
    run_instr(6'h00, 6'h20, 1, 0, 1);
    run_instr(6'h00, 6'h22, 1, 0, 1);
    run_instr(6'h00, 6'h24, 1, 0, 1);
    run_instr(6'h08, 6'h11, 0, 0, 1);
    run_instr(6'h08, 6'h11, 1, 0, 1);
    run_instr(6'h23, 6'h00, 0, 0, 1);
    run_instr(6'h2B, 6'h00, 0, 0, 1);
    run_instr(6'h04, 6'h00, 0, 1, 1);
    run_instr(6'h04, 6'h00, 0, 0, 1);
    run_instr(6'h05, 6'h00, 0, 1, 1);
    run_instr(6'h05, 6'h00, 0, 0, 1);
    run_instr(6'h02, 6'h00, 0, 0, 1);
    run_instr(6'h00, 6'h13, 0, 0, 1);
    run_instr(6'h00, 6'h18, 0, 0, 33);
    run_instr(6'h3F, 6'h00, 0, 0, 1);
    run_instr(6'h00, 6'h3F, 0, 0, 1);

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 11)];
      if (op == 6'h00 && $urandom_range(0, 11) == 0) op = 6'($urandom);
      fn = (op == 6'h00) ? fns[$urandom_range(0, 5)] : 6'($urandom);
      if (op == 6'h00 && fn == 6'h00) fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 40)));
    end

    OPCODE = 6'h3F; FUNCT = 6'h00;
    fetch_decode();
    w = '0; w.src_b = 2'd1; w.alu_op = 4'd2; w.aluout_w = 1;
    rnd_flags(); cyc("abort_exc_epc", w);
    w = '0; w.epc_w = 1; w.mux_mem = 2'd3; w.mux_exc = 2'd0;
    rnd_flags(); cyc("abort_exc_rd", w);
    w = '0; w.mux_mem = 2'd3; w.mux_exc = 2'd0;
    rnd_flags(); #1 check("abort_exc_wait", obs, w);
    #2 reset = 1'b0;
    #1 check("abort_reset_low", obs, '0);
    repeat (3) begin @(negedge clk); rnd_flags(); #1 check("abort_hold", obs, '0); end
    @(negedge clk); reset = 1'b1;
    rnd_flags(); cyc("abort_release", '0);
    run_instr(6'h00, 6'h20, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
